// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one external memory port between instruction fetch and
// load/store. Data has priority, stalls freeze the pipeline, and a timed-out access sets a sticky error.
module mem_port_arbiter #(
   parameter int WIDTH     = 24,
   parameter int ADDRWIDTH = 24,
   parameter int MAXWAIT   = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fetchReq,
   input  logic [ADDRWIDTH-1:0] fetchAddress,
   input  logic                 dataReadReq,
   input  logic                 dataWriteReq,
   input  logic [ADDRWIDTH-1:0] dataAddress,
   input  logic [WIDTH-1:0]     dataWriteData,
   input  logic                 memReady,
   input  logic [WIDTH-1:0]     memReadData,
   output logic                 memReq,
   output logic                 memWrite,
   output logic [ADDRWIDTH-1:0] memAddress,
   output logic [WIDTH-1:0]     memWriteData,
   output logic [WIDTH-1:0]     instructionF,
   output logic                 fetchValid,
   output logic [WIDTH-1:0]     readDataM,
   output logic                 dataValid,
   output logic                 fetchStall,
   output logic                 memStall,
   output logic                 memError
);

   localparam int CW = $clog2(MAXWAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAXWAIT - 1);
   localparam logic [CW-1:0] WAIT_FULL = CW'(MAXWAIT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      FETCH  = 3'd2,
      DONE_D = 3'd3,
      DONE_F = 3'd4,
      ERR    = 3'd5
   } state_t;

   state_t        state_r;
   logic [CW-1:0] wait_cnt_r;
   logic          data_req_s;

   assign data_req_s = dataReadReq | dataWriteReq;

   // Freeze signals: a data access holds the whole pipeline until its completion pulse.
   assign memStall   = (data_req_s & ~dataValid) | (state_r == ERR);
   assign fetchStall = memStall | (fetchReq & ~fetchValid);

   // Access sequencer: launch, wait for memReady or timeout, pulse completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         wait_cnt_r   <= '0;
         memReq       <= 1'b0;
         memWrite     <= 1'b0;
         memAddress   <= '0;
         memWriteData <= '0;
         instructionF <= '0;
         fetchValid   <= 1'b0;
         readDataM    <= '0;
         dataValid    <= 1'b0;
         memError     <= 1'b0;
      end else begin
         dataValid  <= 1'b0;
         fetchValid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (data_req_s) begin
                  memAddress   <= dataAddress;
                  memWrite     <= dataWriteReq;
                  memWriteData <= dataWriteData;
                  memReq       <= 1'b1;
                  wait_cnt_r   <= '0;
                  state_r      <= DATA;
               end else if (fetchReq) begin
                  memAddress <= fetchAddress;
                  memWrite   <= 1'b0;
                  memReq     <= 1'b1;
                  wait_cnt_r <= '0;
                  state_r    <= FETCH;
               end else begin
                  state_r <= IDLE;
               end
            end
            DATA, FETCH: begin
               if (memReady) begin
                  memReq <= 1'b0;
                  if (state_r == DATA) begin
                     if (!memWrite) begin
                        readDataM <= memReadData;
                     end
                     dataValid <= 1'b1;
                     state_r   <= DONE_D;
                  end else begin
                     instructionF <= memReadData;
                     fetchValid   <= 1'b1;
                     state_r      <= DONE_F;
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  // This is the MAXWAIT-th unanswered cycle: give up on the access.
                  wait_cnt_r <= WAIT_FULL;
                  memReq     <= 1'b0;
                  memError   <= 1'b1;
                  state_r    <= ERR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            DONE_D, DONE_F: begin
               state_r <= IDLE;
            end
            ERR: begin
               state_r <= ERR;
            end
            default: begin
               memReq   <= 1'b0;
               memError <= 1'b1;
               state_r  <= ERR;
            end
         endcase
      end
   end

endmodule
